// File: rtl/dht_multi_reader.sv
// dht_multi_reader: sweeps N_CH single-wire DHT-style sensors in channel order,
// decodes each 40-bit frame, keeps per-channel temperature/humidity with
// valid/error flags, and drives a fan enable with hysteresis after each sweep.
module dht_multi_reader #(
  parameter int CLK_HZ        = 100000000,
  parameter int N_CH          = 2,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 200,
  parameter int BIT_THRESH_US = 50,
  parameter int POLL_MS       = 2000,
  parameter int FAN_ON        = 30,
  parameter int FAN_OFF       = 28
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              AUTO,
  inout  wire  [N_CH-1:0]   DHT_DATA,
  output logic [8*N_CH-1:0] TEMP_INT,
  output logic [8*N_CH-1:0] HUM_INT,
  output logic [N_CH-1:0]   VALID,
  output logic [N_CH-1:0]   ERR,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAN
);
  localparam int DIV     = CLK_HZ / 1000000;
  localparam int POLL_US = POLL_MS * 1000;
  localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_NEXT
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     div_cnt, tm_cnt, poll_cnt;
  logic            tick, poll_exp, trig, line, armed, tmo, wait_st, last_ch, sum_ok;
  logic            any_hot, all_cool, any_v, fan_nx;
  logic [N_CH-1:0] sync1, sync2, drv;
  logic [CW-1:0]   ch;
  logic [39:0]     shreg;
  logic [5:0]      bit_cnt;
  logic [7:0]      sum;

  assign tick     = (div_cnt == 32'(DIV - 1));
  assign poll_exp = AUTO && tick && (poll_cnt == 32'(POLL_US - 1));
  assign trig     = START || poll_exp;
  assign line     = sync2[ch];
  assign last_ch  = (ch == CW'(N_CH - 1));
  assign wait_st  = (state == S_RELEASE) || (state == S_RESP_LOW) || (state == S_RESP_HIGH) ||
                    (state == S_BIT_LOW) || (state == S_BIT_HIGH);
  assign tmo      = wait_st && tick && (tm_cnt == 32'(TIMEOUT_US - 1));
  // byte4 is the first byte received and sits at the top of the shift register
  assign sum      = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign sum_ok   = (sum == shreg[7:0]);

  // open drain: only ever pull low, otherwise release
  for (genvar i = 0; i < N_CH; i++) begin : g_line
    assign DHT_DATA[i] = drv[i] ? 1'b0 : 1'bz;
  end

  // 1 us tick divider
  always_ff @(posedge CLK) begin
    if (RST || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 32'd1;
  end

  // two-flop synchroniser on every sensor line (idle level is high)
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= DHT_DATA;
      sync2 <= sync1;
    end
  end

  // poll period counter; restarts when a sweep begins or auto mode is off
  always_ff @(posedge CLK) begin
    if (RST || !AUTO || (state == S_IDLE && trig)) poll_cnt <= '0;
    else if (poll_exp)                             poll_cnt <= '0;
    else if (tick)                                 poll_cnt <= poll_cnt + 32'd1;
  end

  // per-state microsecond timer, cleared on every state change
  always_ff @(posedge CLK) begin
    if (RST || state_nx != state) tm_cnt <= '0;
    else if (tick && state != S_IDLE) tm_cnt <= tm_cnt + 32'd1;
  end

  // RELEASE must see our own low drain out of the synchroniser before it
  // accepts the sensor's response low
  always_ff @(posedge CLK) begin
    if (RST || state != S_RELEASE) armed <= 1'b0;
    else if (line)                 armed <= 1'b1;
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state, line drive and busy
  always_comb begin
    state_nx = state;
    drv      = '0;
    BUSY     = 1'b1;
    case (state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (trig) state_nx = S_START_LOW;
      end
      S_START_LOW: begin
        drv[ch] = 1'b1;
        if (tick && tm_cnt == 32'(START_LOW_US - 1)) state_nx = S_RELEASE;
      end
      S_RELEASE:   if (armed && !line) state_nx = S_RESP_LOW;  else if (tmo) state_nx = S_NEXT;
      S_RESP_LOW:  if (line)           state_nx = S_RESP_HIGH; else if (tmo) state_nx = S_NEXT;
      S_RESP_HIGH: if (!line)          state_nx = S_BIT_LOW;   else if (tmo) state_nx = S_NEXT;
      S_BIT_LOW:   if (line)           state_nx = S_BIT_HIGH;  else if (tmo) state_nx = S_NEXT;
      S_BIT_HIGH: begin
        if (!line)    state_nx = (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
        else if (tmo) state_nx = S_NEXT;
      end
      S_CHECK:     state_nx = S_NEXT;
      S_NEXT:      state_nx = last_ch ? S_IDLE : S_START_LOW;
      default:     state_nx = S_IDLE;
    endcase
  end

  // fan hysteresis decision over the currently valid channels
  always_comb begin
    any_hot  = 1'b0;
    all_cool = 1'b1;
    any_v    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (VALID[i]) begin
        any_v = 1'b1;
        if (TEMP_INT[8*i +: 8] >= 8'(FAN_ON))  any_hot  = 1'b1;
        if (TEMP_INT[8*i +: 8] >= 8'(FAN_OFF)) all_cool = 1'b0;
      end
    end
    fan_nx = FAN;
    if (any_hot)               fan_nx = 1'b1;
    else if (any_v && all_cool) fan_nx = 1'b0;
  end

  // channel walk, bit capture, result registers, done pulse and fan
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch       <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      TEMP_INT <= '0;
      HUM_INT  <= '0;
      VALID    <= '0;
      ERR      <= '0;
      DONE     <= 1'b0;
      FAN      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == S_IDLE && trig) ch <= '0;
      if (state == S_START_LOW) bit_cnt <= '0;
      if (state == S_BIT_HIGH && !line) begin
        shreg   <= {shreg[38:0], tm_cnt > 32'(BIT_THRESH_US)};
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state == S_CHECK) begin
        if (sum_ok) begin
          HUM_INT[8*ch +: 8]  <= shreg[39:32];
          TEMP_INT[8*ch +: 8] <= shreg[23:16];
          VALID[ch]           <= 1'b1;
          ERR[ch]             <= 1'b0;
        end else begin
          VALID[ch] <= 1'b0;
          ERR[ch]   <= 1'b1;
        end
      end
      // any entry to NEXT that does not come from CHECK is a wait timeout
      if (state_nx == S_NEXT && state != S_CHECK) begin
        VALID[ch] <= 1'b0;
        ERR[ch]   <= 1'b1;
      end
      if (state == S_NEXT) begin
        if (last_ch) begin
          DONE <= 1'b1;
          FAN  <= fan_nx;
        end else begin
          ch <= ch + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dht_multi_reader.sv
// tb_dht_multi_reader: two behavioural sensors on pulled-up lines, a
// frame-level reference model of the expected registers, randomized frames.
`timescale 1ns/1ps
module tb_dht_multi_reader;
  localparam int TMO = 200;

  logic        clk = 0, rst = 1, start = 0, auto_en = 0;
  wire  [1:0]  dht;
  logic [15:0] temp, hum;
  logic [1:0]  valid, err;
  logic        busy, done, fan;

  int checks = 0, failures = 0;
  int done_cnt = 0, busy_rise = 0;
  logic busy_q = 0;
  realtime t_rel = 0, t_err = 0;

  logic [39:0] frame [2];
  bit          respond [2];
  logic [7:0]  m_temp [2], m_hum [2];
  bit          m_valid [2], m_err [2], m_fan;

  always #500 clk = ~clk;

  dht_multi_reader #(
    .CLK_HZ(1000000), .N_CH(2), .START_LOW_US(100), .TIMEOUT_US(TMO),
    .BIT_THRESH_US(50), .POLL_MS(1), .FAN_ON(30), .FAN_OFF(28)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .AUTO(auto_en), .DHT_DATA(dht),
    .TEMP_INT(temp), .HUM_INT(hum), .VALID(valid), .ERR(err),
    .BUSY(busy), .DONE(done), .FAN(fan)
  );

  pullup pu0 (dht[0]);
  pullup pu1 (dht[1]);

  // sensor model: after the host releases, answer (if enabled) with
  // 40 us low / 40 us high, then 40 bits of 20 us low + 20/70 us high
  for (genvar g = 0; g < 2; g++) begin : g_sen
    logic low = 0, hi = 0;
    logic [39:0] fr;
    assign dht[g] = low ? 1'b0 : 1'bz;
    initial begin
      forever begin
        @(negedge dht[g]);
        @(posedge dht[g]);
        if (respond[g]) begin
          fr = frame[g];
          #20250 low = 1;
          #40000 low = 0;
          #40000;
          for (int k = 39; k >= 0; k--) begin
            low = 1;
            #20000 low = 0; hi = 1;
            if (fr[k]) #70000; else #20000;
            hi = 0;
          end
          low = 1;
          #20000 low = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && !busy_q) busy_rise++;
    busy_q = busy;
  end
  always @(posedge dht[1]) t_rel = $realtime;
  always @(posedge err[1]) t_err = $realtime;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] mkframe(input logic [7:0] h, input logic [7:0] t, input bit bad);
    logic [7:0] b3, b1, cs;
    b3 = 8'($urandom_range(0, 9));
    b1 = 8'($urandom_range(0, 9));
    cs = 8'(h + b3 + t + b1 + (bad ? 1 : 0));
    return {h, b3, t, b1, cs};
  endfunction

  // reference: frame-level result per channel, then fan hysteresis
  task automatic model_sweep();
    bit hot, cool, anyv;
    for (int c = 0; c < 2; c++) begin
      logic [7:0] b4, b3, b2, b1, b0;
      int s;
      {b4, b3, b2, b1, b0} = frame[c];
      s = b4 + b3 + b2 + b1;
      if (!respond[c]) begin
        m_err[c] = 1; m_valid[c] = 0;
      end else if ((s % 256) == b0) begin
        m_hum[c] = b4; m_temp[c] = b2; m_valid[c] = 1; m_err[c] = 0;
      end else begin
        m_err[c] = 1; m_valid[c] = 0;
      end
    end
    hot = 0; cool = 1; anyv = 0;
    for (int c = 0; c < 2; c++) if (m_valid[c]) begin
      anyv = 1;
      if (m_temp[c] >= 30) hot = 1;
      if (m_temp[c] >= 28) cool = 0;
    end
    if (hot) m_fan = 1;
    else if (anyv && cool) m_fan = 0;
  endtask

  task automatic chk_state(input string s);
    chk({s, "_temp"},  temp,  {m_temp[1], m_temp[0]});
    chk({s, "_hum"},   hum,   {m_hum[1], m_hum[0]});
    chk({s, "_valid"}, valid, {m_valid[1], m_valid[0]});
    chk({s, "_err"},   err,   {m_err[1], m_err[0]});
    chk({s, "_fan"},   fan,   m_fan);
  endtask

  task automatic run_sweep(input string s, input logic [39:0] f0, input logic [39:0] f1,
                           input bit r0, input bit r1);
    int n;
    frame[0] = f0; frame[1] = f1; respond[0] = r0; respond[1] = r1;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    chk({s, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 20000) begin @(negedge clk); n++; end
    chk({s, "_done_seen"}, done, 1);
    chk({s, "_busy_in_done"}, busy, 0);
    model_sweep();
    chk_state(s);
    @(negedge clk);
    chk({s, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, d0, b0;
    logic [39:0] f1;
    for (int c = 0; c < 2; c++) begin
      frame[c] = '0; respond[c] = 0; m_temp[c] = 0; m_hum[c] = 0; m_valid[c] = 0; m_err[c] = 0;
    end
    m_fan = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lines", dht, 2'b11);
    chk_state("rst");
    rst = 0;
    @(negedge clk);

    // good frame on ch0, random good frame on ch1
    f1 = mkframe(8'($urandom_range(20, 90)), 8'($urandom_range(15, 35)), 0);
    run_sweep("a", 40'h37_00_1A_00_51, f1, 1, 1);
    chk("a_hum0", hum[7:0], 8'h37);
    chk("a_temp0", temp[7:0], 8'h1A);

    // bad checksum on ch0, silent ch1
    run_sweep("b", 40'h37_00_1A_00_52, f1, 1, 0);
    chk("b_temp0_hold", temp[7:0], 8'h1A);
    chk("b_tmo_us", 64'($rtoi((t_err - t_rel) / 1000.0 + 0.5)), 64'(TMO));

    // fan hysteresis
    run_sweep("c", mkframe(8'd50, 8'd30, 0), f1, 1, 0);
    chk("c_fan", fan, 1);
    run_sweep("d", mkframe(8'd50, 8'd29, 0), f1, 1, 0);
    chk("d_fan", fan, 1);
    run_sweep("e", mkframe(8'd50, 8'd27, 0), f1, 1, 0);
    chk("e_fan", fan, 0);

    // randomized sweeps
    for (int r = 0; r < 3; r++) begin
      run_sweep($sformatf("rnd%0d", r),
        mkframe(8'($urandom_range(0, 99)), 8'($urandom_range(20, 35)), $urandom_range(0, 3) == 0),
        mkframe(8'($urandom_range(0, 99)), 8'($urandom_range(20, 35)), $urandom_range(0, 3) == 0),
        $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
    end

    // START while busy must not add sweeps
    frame[0] = '0; frame[1] = '0; respond[0] = 0; respond[1] = 0;
    d0 = done_cnt; b0 = busy_rise;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (50) @(negedge clk);
    start = 1; @(negedge clk) start = 0;
    repeat (400) @(negedge clk);
    start = 1; @(negedge clk) start = 0;
    repeat (1500) @(negedge clk);
    chk("sb_done_cnt", 64'(done_cnt - d0), 1);
    chk("sb_busy_rise", 64'(busy_rise - b0), 1);
    model_sweep();
    chk_state("sb");

    // auto polling, with START landing on a poll expiry
    auto_en = 1;
    n = 0;
    while (!busy && n < 5000) begin @(negedge clk); n++; end
    chk("auto_first", busy, 1);
    repeat (999) @(negedge clk);
    chk("auto_gap", busy, 0);
    d0 = done_cnt; b0 = busy_rise;
    start = 1;
    @(negedge clk) start = 0;
    chk("auto_period", busy, 1);
    repeat (998) @(negedge clk);
    chk("auto_coinc_done", 64'(done_cnt - d0), 1);
    chk("auto_coinc_rise", 64'(busy_rise - b0), 1);
    @(negedge clk);
    chk("auto_idle", busy, 0);
    @(negedge clk);
    chk("auto_next", busy, 1);
    auto_en = 0;
    n = 0;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    chk("auto_last_done", done, 1);
    model_sweep();
    chk_state("auto");

    // reset in the middle of a data bit high phase
    frame[0] = mkframe(8'd44, 8'd31, 0); respond[0] = 1; respond[1] = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    n = 0;
    while (!g_sen[0].hi && n < 5000) begin @(negedge clk); n++; end
    chk("rst_in_bit", g_sen[0].hi, 1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      m_temp[c] = 0; m_hum[c] = 0; m_valid[c] = 0; m_err[c] = 0;
    end
    m_fan = 0;
    chk("mrst_lines", dht, 2'b11);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk_state("mrst");
    rst = 0;
    repeat (3000) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
